fpadd_accum_ctrl: RTL
=====================

Name: fpadd_accum_ctrl

Overview:
Initiator-side controller for the team's multi-cycle start/done FP32 adder. It accepts a packet of IEEE-754 single-precision values over a valid/ready stream. It issues one adder operation per additional element, with the running sum on operand A and the new element on operand B. It returns the packet total on a valid/ready result port. The block sits between the operand stream source and one adder instance, and owns the adder's start, a and b inputs.

Parameters:
TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT_DONE before an abort (used only with FPACC_TIMEOUT_EN).
COUNT_W, 8, width of the element counter; the counter saturates at all-ones.

Ports:
clk  input  1  clock; all logic is on the rising edge.
reset  input  1  asynchronous, active-low reset.
in_valid  input  1  input element valid.
in_data  input  32  FP32 element.
in_last  input  1  marks the final element of a packet.
in_ready  output  1  block accepts an element this cycle.
add_start  output  1  one-cycle start pulse to the adder.
add_a  output  32  adder operand A (running sum).
add_b  output  32  adder operand B (new element).
add_sum  input  32  adder result.
add_done  input  1  adder completion flag; level-sensitive and stale until the adder sees start.
res_valid  output  1  packet result valid.
res_data  output  32  FP32 packet sum.
res_count  output  COUNT_W  number of elements accumulated, saturating.
res_ready  input  1  result consumer ready.
res_err  output  1  result is an aborted packet (timeout only).

Behaviour:
- Reset values (reset low, asynchronous): all outputs 0, accumulator 0, counter 0, state IDLE.
- Input handshake: an element transfers when in_valid and in_ready are both high.
- Result handshake: the result transfers when res_valid and res_ready are both high.
- IDLE:
  - in_ready=1.
  - On handshake: acc<=in_data, count<=1.
  - If in_last: go to OUTPUT (no adder operation is issued). Otherwise go to WAIT_OP.
- WAIT_OP:
  - in_ready=1.
  - On handshake: add_b<=in_data, add_a<=acc, latch last_flag<=in_last, count<=count+1 (saturating). Go to ISSUE.
- ISSUE:
  - add_start=1 for exactly this one cycle. Go to SETTLE.
- SETTLE:
  - Exactly one cycle; add_done is ignored. This masks the stale done left over from the previous operation.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - On add_done=1: acc<=add_sum. Go to OUTPUT if last_flag, otherwise to WAIT_OP.
- OUTPUT:
  - res_valid=1.
  - res_data=acc, res_count=count, res_err=err_flag.
  - All three are held stable until res_ready.
  - On transfer: clear err_flag and go to IDLE.
- add_a and add_b hold their values from the handshake until the next WAIT_OP handshake.
- in_ready=0 in ISSUE, SETTLE, WAIT_DONE and OUTPUT. The block does no input buffering.
- Minimum per-element latency: handshake cycle, plus ISSUE, plus SETTLE, plus the adder's done latency.
- Reset mid-operation:
  - The state machine returns to IDLE and add_start drops immediately.
  - The adder is not reset by this block; its next start reinitialises it.
  - A partially accumulated packet is lost. No result is emitted for it.
- No sign, NaN or Inf handling: special values pass through the adder unchanged.

Optional Feature:
FPACC_TIMEOUT_EN
- Defined:
  - A cycle counter runs in WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES without add_done: set err_flag and leave acc unchanged.
  - If last_flag is set, go to OUTPUT. Otherwise go to DRAIN.
  - DRAIN: in_ready=1, elements are discarded, count is not updated; the element with in_last=1 moves the block to OUTPUT.
- Not defined:
  - No counter and no DRAIN state; WAIT_DONE waits indefinitely.
  - res_err is tied to 0.

Decomposition:
- Shared package fp_pkg:
  - state enum (IDLE, WAIT_OP, ISSUE, SETTLE, WAIT_DONE, OUTPUT, DRAIN).
  - FP32 constants: FP_ONE=32'h3F800000, FP_ZERO=0.
  - field widths: EXP_W=8, MANT_W=23.
- No sub-module. The timeout counter is inline.
- The bench instantiates the existing adder as the responder.

Test Plan:
- Packet 0x3F800000, 0x40000000(last) → one add_start pulse; res_data=0x40400000, res_count=2, res_err=0.
- Single element 0x40A00000(last) → no add_start; res_data=0x40A00000, res_count=1.
- Packet 1.0, 1.0, 2.0(last) → two add_start pulses, each one cycle wide; res_data=0x40800000, res_count=3.
- Stale done: adder model holds add_done=1 from the previous op; a second op's add_sum arrives 5 cycles later → acc captures the new sum, not the stale value; the result is correct.
- Backpressure: res_ready held low for 5 cycles → res_valid and res_data stable throughout, in_ready=0; IDLE is entered on the cycle after the transfer.
- Reset low during WAIT_DONE → add_start=0 and res_valid=0 immediately. After release, a fresh packet 3.0, 1.0 sums to 0x40800000. With FPACC_TIMEOUT_EN and add_done stuck at 0 → res_err=1 after 64 WAIT_DONE cycles; a 3-element packet drains to OUTPUT with res_count=2.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP32 accumulator definitions: controller states,
// FP32 constants and IEEE-754 single-precision field widths.
package fp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_OP,
    ISSUE,
    SETTLE,
    WAIT_DONE,
    OUTPUT,
    DRAIN
  } state_t;

  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;

endpackage

// File: rtl/fpadd_accum_ctrl.sv
// FP32 packet accumulator driving a multi-cycle start/done adder.
// Ports: clk, reset (async active-low); in_valid/in_data/in_last/in_ready
// element stream; add_start/add_a/add_b/add_sum/add_done adder side;
// res_valid/res_data/res_count/res_err/res_ready result stream.
// Optional macro FPACC_TIMEOUT_EN: WAIT_DONE timeout, DRAIN, res_err.
module fpadd_accum_ctrl
  import fp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int COUNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               add_start,
  output logic [31:0]        add_a,
  output logic [31:0]        add_b,
  input  logic [31:0]        add_sum,
  input  logic               add_done,
  output logic               res_valid,
  output logic [31:0]        res_data,
  output logic [COUNT_W-1:0] res_count,
  input  logic               res_ready,
  output logic               res_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t state, state_nx;

  logic [31:0]        acc;
  logic [COUNT_W-1:0] count;
  logic               last_flag;
  logic               in_hs;
  logic               tmo;

  assign in_hs = in_valid && in_ready;

`ifdef FPACC_TIMEOUT_EN
  logic [TW-1:0] tcnt;
  logic          err_flag;

  // Timeout fires on the last of TIMEOUT_CYCLES idle WAIT_DONE cycles
  assign tmo = (state == WAIT_DONE) && !add_done &&
               (tcnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcnt     <= '0;
      err_flag <= 1'b0;
    end else begin
      if (state == WAIT_DONE && !add_done && !tmo)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;
      if (tmo)
        err_flag <= 1'b1;
      else if (state == OUTPUT && res_ready)
        err_flag <= 1'b0;
    end
  end

  assign res_err = err_flag;
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0) && (TW != 0);
  assign tmo        = 1'b0;
  assign res_err    = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    add_start = 1'b0;
    res_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = in_last ? OUTPUT : WAIT_OP;
      end
      WAIT_OP: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = ISSUE;
      end
      ISSUE: begin
        add_start = 1'b1;
        state_nx  = SETTLE;
      end
      // One blind cycle: add_done still shows the previous op
      SETTLE: state_nx = WAIT_DONE;
      WAIT_DONE: begin
        if (add_done)
          state_nx = last_flag ? OUTPUT : WAIT_OP;
        else if (tmo)
          state_nx = last_flag ? OUTPUT : DRAIN;
      end
      OUTPUT: begin
        res_valid = 1'b1;
        if (res_ready)
          state_nx = IDLE;
      end
      DRAIN: begin
`ifdef FPACC_TIMEOUT_EN
        in_ready = 1'b1;
        if (in_valid && in_last)
          state_nx = OUTPUT;
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= FP_ZERO;
      count     <= '0;
      add_a     <= '0;
      add_b     <= '0;
      last_flag <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_hs) begin
        acc   <= in_data;
        count <= COUNT_W'(1);
      end
      if (state == WAIT_OP && in_hs) begin
        add_a     <= acc;
        add_b     <= in_data;
        last_flag <= in_last;
        if (count != '1)
          count <= count + COUNT_W'(1);
      end
      if (state == WAIT_DONE && add_done)
        acc <= add_sum;
    end
  end

  assign res_data  = acc;
  assign res_count = count;

endmodule
